frame_packer: RTL and testbench

FRAME_PACKER -- requirements
Module: frame_packer

---
 rtl/frame_packer.sv | 144 ++++++++++++++
 tb/tb_frame_packer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_packer.sv
// Streams a 4-byte big-endian height/width header then h*w pixel bytes (row-major) from pixel memory to a UART.
// Latency: first header strobe 2 cycles after start; each pixel strobe 3 cycles after the preceding tx_done.
// Backpressure: one byte in flight; the next strobe waits for tx_done, and start is ignored while busy.
module frame_packer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] frame_h,
    input  logic [15:0] frame_w,
    output logic [15:0] rd_H,
    output logic [15:0] rd_W,
    input  logic [7:0]  rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_done,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] MAX_W = 16'(IMG_WIDTH);
    localparam logic [15:0] MAX_H = 16'(IMG_HEIGHT);

    typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, SEND, WAIT, FIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lat_h;
    logic [15:0] lat_w;
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] h_clamp;
    logic [15:0] w_clamp;
    logic [1:0]  hdr_idx;
    logic [31:0] pix_left;
    logic [7:0]  hdr_byte;

    assign h_clamp = (frame_h > MAX_H) ? MAX_H : frame_h;
    assign w_clamp = (frame_w > MAX_W) ? MAX_W : frame_w;

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    always_comb begin
        hdr_byte = 8'd0;
        case (hdr_idx)
            2'd0: hdr_byte = lat_h[15:8];
            2'd1: hdr_byte = lat_h[7:0];
            2'd2: hdr_byte = lat_w[15:8];
            2'd3: hdr_byte = lat_w[7:0];
            default: hdr_byte = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = HDR;
            HDR:   state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    if (hdr_idx != 2'd3)       state_nxt = HDR;
                    else if (pix_left != 32'd0) state_nxt = FETCH;
                    else                        state_nxt = FIN;
                end
            end
            FETCH: state_nxt = LATCH;
            LATCH: state_nxt = SEND;
            SEND:  state_nxt = WAIT;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_data doubles as the pixel holding register: it is loaded in LATCH and presented during SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_h    <= 16'd0;
            lat_w    <= 16'd0;
            row      <= 16'd0;
            col      <= 16'd0;
            hdr_idx  <= 2'd0;
            pix_left <= 32'd0;
            rd_H     <= 16'd0;
            rd_W     <= 16'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_h    <= h_clamp;
                        lat_w    <= w_clamp;
                        hdr_idx  <= 2'd0;
                        row      <= 16'd0;
                        col      <= 16'd0;
                        pix_left <= 32'(h_clamp) * 32'(w_clamp);
                    end
                end
                HDR: begin
                    tx_valid <= 1'b1;
                    tx_data  <= hdr_byte;
                end
                WAIT: begin
                    // Addresses are loaded on entry to FETCH so memory sees them during FETCH and LATCH.
                    if (tx_done) begin
                        if (hdr_idx != 2'd3) begin
                            hdr_idx <= hdr_idx + 2'd1;
                        end else if (pix_left != 32'd0) begin
                            rd_H <= row;
                            rd_W <= col;
                        end
                    end
                end
                LATCH: begin
                    tx_valid <= 1'b1;
                    tx_data  <= rd_data;
                end
                SEND: begin
                    pix_left <= pix_left - 32'd1;
                    if (col == lat_w - 16'd1) begin
                        col <= 16'd0;
                        row <= row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Randomized scoreboard bench for frame_packer: a byte-stream model fills an expectation queue, a monitor checks the UART side.
module tb_frame_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] frame_h;
    logic [15:0] frame_w;
    logic [15:0] rd_H;
    logic [15:0] rd_W;
    logic [7:0]  rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_done;
    logic        busy;
    logic        done;
    logic        tx_done_drv;
    logic        extra_a;
    logic        extra_b;

    assign tx_done = tx_done_drv | extra_a | extra_b;

    frame_packer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .frame_h  (frame_h),
        .frame_w  (frame_w),
        .rd_H     (rd_H),
        .rd_W     (rd_W),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_done  (tx_done),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [15:0] r, input logic [15:0] c);
        logic [31:0] v;
        v = 32'(r) * 32'd16 + 32'(c);
        return v[7:0];
    endfunction

    // Synchronous pixel memory: data valid one cycle after the address.
    always @(posedge clk) rd_data <= pix(rd_H, rd_W);

    typedef struct {
        logic [7:0] b;
        bit         is_pix;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    int   done_cnt;
    int   outstanding;
    int   last_done_cyc;
    int   tx_dly;
    bit   inject_fetch;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic monitor();
        exp_t        e;
        logic [15:0] prev_h = 16'd0;
        logic [15:0] prev_w = 16'd0;
        bit          prev_done = 1'b0;
        bit          prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                outstanding = 0;
            end else begin
                if (tx_valid) begin
                    chk("one_outstanding", 32'(outstanding), 32'd0);
                    outstanding = 1;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(tx_data), 32'(e.b));
                        if (e.is_pix) chk("pix_latency", 32'(cyc - last_done_cyc), 32'd3);
                    end
                end
                if (tx_done_drv) begin
                    if (outstanding > 0) outstanding--;
                    last_done_cyc = cyc;
                end
                if (done) done_cnt++;
                if (!prev_rst && (rd_H != prev_h || rd_W != prev_w)) begin
                    chk("addr_change_after_done", 32'(prev_done), 32'd1);
                end
            end
            prev_h    = rd_H;
            prev_w    = rd_W;
            prev_done = tx_done_drv;
            prev_rst  = reset;
        end
    endtask

    task automatic transmitter();
        forever begin
            @(negedge clk);
            if (tx_valid && !reset) begin
                repeat (tx_dly) @(posedge clk);
                #1 tx_done_drv = 1'b1;
                @(posedge clk);
                #1 tx_done_drv = 1'b0;
                if (inject_fetch) begin
                    extra_b = 1'b1;
                    @(posedge clk);
                    #1 extra_b = 1'b0;
                end
            end
        end
    endtask

    task automatic push_frame(input int h, input int w);
        exp_t e;
        int   ch;
        int   cw;
        ch = (h > 480) ? 480 : h;
        cw = (w > 640) ? 640 : w;
        e.is_pix = 1'b0;
        e.b = 8'(ch >> 8); exp_q.push_back(e);
        e.b = 8'(ch);      exp_q.push_back(e);
        e.b = 8'(cw >> 8); exp_q.push_back(e);
        e.b = 8'(cw);      exp_q.push_back(e);
        e.is_pix = 1'b1;
        for (int r = 0; r < ch; r++) begin
            for (int c = 0; c < cw; c++) begin
                e.b = pix(16'(r), 16'(c));
                exp_q.push_back(e);
            end
        end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_frame(input int h, input int w, input bit noise, input bit inject, input bit done_start);
        int budget;
        int dc0;
        bit seen;
        int nbytes;
        nbytes = 4 + ((h > 480) ? 480 : h) * ((w > 640) ? 640 : w);
        push_frame(h, w);
        dc0 = done_cnt;
        inject_fetch = inject;
        frame_h = 16'(h);
        frame_w = 16'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frame_h = 16'($urandom);
        frame_w = 16'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("no_early_valid", 32'(tx_valid), 32'd0);
        if (inject) extra_a = 1'b1;
        @(negedge clk);
        extra_a = 1'b0;
        chk("hdr_latency", 32'(tx_valid), 32'd1);
        budget = nbytes * (tx_dly + 8) + 20;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else if (noise && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                frame_h = 16'($urandom_range(0, 7));
                frame_w = 16'($urandom_range(0, 7));
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        if (!seen) exp_q.delete();
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("no_valid_after_done", 32'(tx_valid), 32'd0);
        chk("done_pulse_count", 32'(done_cnt - dc0), 32'd1);
        inject_fetch = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_H", 32'(rd_H), 32'd0);
        chk("rst_rd_W", 32'(rd_W), 32'd0);
    endtask

    task automatic reset_mid_frame();
        int k;
        int dc0;
        push_frame(2, 3);
        dc0 = done_cnt;
        frame_h = 16'd2;
        frame_w = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 200 && k < 6; i++) begin
            @(negedge clk);
            if (tx_valid) k++;
        end
        chk("six_bytes_before_reset", 32'(k), 32'd6);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (tx_dly + 10) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt - dc0), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);
        run_frame(1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        frame_h = 16'd0;
        frame_w = 16'd0;
        tx_done_drv = 1'b0;
        extra_a = 1'b0;
        extra_b = 1'b0;
        inject_fetch = 1'b0;
        tx_dly = 3;
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        done_cnt = 0;
        outstanding = 0;
        last_done_cyc = 0;
        fork
            monitor();
            transmitter();
        join_none
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);

        run_frame(5, 0, 1'b0, 1'b0, 1'b0);
        chk("zero_w_rd_H", 32'(rd_H), 32'd0);
        chk("zero_w_rd_W", 32'(rd_W), 32'd0);
        run_frame(0, 7, 1'b0, 1'b0, 1'b0);

        tx_dly = 5;
        run_frame(2, 3, 1'b0, 1'b0, 1'b0);

        tx_dly = 2;
        run_frame(1, 1000, 1'b0, 1'b0, 1'b0);
        run_frame(1000, 1, 1'b0, 1'b0, 1'b0);

        tx_dly = 4;
        run_frame(3, 4, 1'b1, 1'b1, 1'b1);

        reset_mid_frame();

        for (int t = 0; t < 8; t++) begin
            tx_dly = $urandom_range(1, 6);
            run_frame($urandom_range(0, 4), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        tx_dly = 1000;
        run_frame(1, 3, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
